// File: rtl/multicycle_cu_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, function
// codes, one-hot ALU bit positions, next-PC selects and the FSM state type.
package cu_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Bit positions inside the one-hot alu_op bus
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
  localparam int ALU_NUM  = 12;

  // Next-PC source selects
  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_JUMP   = 2'b01;
  localparam logic [1:0] NPC_BRANCH = 2'b10;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } cu_state_t;

  // Instruction class flags produced by the decoder
  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic br_ne;
    logic jump;
    logic illegal;
  } inst_class_t;

endpackage

// File: rtl/multicycle_cu_decoder.sv
// Combinational instruction decoder: op/func to class flags, one-hot ALU
// operation and the static datapath selects. Illegal encodings yield all-zero
// alu_op and selects.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int ALU_OP_W = 16
) (
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  output inst_class_t         cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                src1_is_sa,
  output logic                src2_is_imm,
  output logic                imm_zext,
  output logic                dst_is_rt,
  output logic                reg_from_dm
);

  logic [ALU_NUM-1:0] op_oh;

  // Decode op/func into class, ALU one-hot and static selects
  always_comb begin
    cls         = '0;
    op_oh       = '0;
    src1_is_sa  = 1'b0;
    src2_is_imm = 1'b0;
    imm_zext    = 1'b0;
    dst_is_rt   = 1'b0;
    reg_from_dm = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls.alu = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: op_oh[ALU_ADD]  = 1'b1;
          FN_SUB, FN_SUBU: op_oh[ALU_SUB]  = 1'b1;
          FN_AND:          op_oh[ALU_AND]  = 1'b1;
          FN_OR:           op_oh[ALU_OR]   = 1'b1;
          FN_XOR:          op_oh[ALU_XOR]  = 1'b1;
          FN_NOR:          op_oh[ALU_NOR]  = 1'b1;
          FN_SLT:          op_oh[ALU_SLT]  = 1'b1;
          FN_SLTU:         op_oh[ALU_SLTU] = 1'b1;
          FN_SLL: begin
            op_oh[ALU_SLL] = 1'b1;
            src1_is_sa     = 1'b1;
          end
          FN_SRL: begin
            op_oh[ALU_SRL] = 1'b1;
            src1_is_sa     = 1'b1;
          end
          FN_SRA: begin
            op_oh[ALU_SRA] = 1'b1;
            src1_is_sa     = 1'b1;
          end
          default: begin
            cls.alu     = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls.alu     = 1'b1;
        src2_is_imm = 1'b1;
        dst_is_rt   = 1'b1;
        case (op)
          OP_ANDI: begin
            op_oh[ALU_AND] = 1'b1;
            imm_zext       = 1'b1;
          end
          OP_ORI: begin
            op_oh[ALU_OR] = 1'b1;
            imm_zext      = 1'b1;
          end
          OP_XORI: begin
            op_oh[ALU_XOR] = 1'b1;
            imm_zext       = 1'b1;
          end
          OP_LUI:  op_oh[ALU_LUI] = 1'b1;
          default: op_oh[ALU_ADD] = 1'b1;
        endcase
      end
      OP_LW: begin
        cls.load       = 1'b1;
        op_oh[ALU_ADD] = 1'b1;
        src2_is_imm    = 1'b1;
        dst_is_rt      = 1'b1;
        reg_from_dm    = 1'b1;
      end
      OP_SW: begin
        cls.store      = 1'b1;
        op_oh[ALU_ADD] = 1'b1;
        src2_is_imm    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls.branch     = 1'b1;
        cls.br_ne      = (op == OP_BNE);
        op_oh[ALU_SUB] = 1'b1;
      end
      OP_J:    cls.jump    = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

  // Upper alu_op bits beyond the defined operations stay zero
  always_comb begin
    alu_op          = '0;
    alu_op[ALU_NUM-1:0] = op_oh;
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EX/MEM/WB around
// req/ready memory handshakes and counts retired instructions.
//
// state | meaning
// IF    | request instruction, latch IR and PC+4 when inst_ready
// ID    | jump completes here, illegal encodings are dropped here
// EX    | ALU step; branches resolve on alu_zero and complete here
// MEM   | data memory access, held until dm_ready
// WB    | register file write, instruction completes
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int ALU_OP_W = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic [4:0]          sa,
  input  logic                alu_zero,
  input  logic                inst_ready,
  input  logic                dm_ready,
  output logic                inst_req,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          npc_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                src1_is_sa,
  output logic                src2_is_imm,
  output logic                imm_zext,
  output logic                dst_is_rt,
  output logic                reg_we,
  output logic                reg_from_dm,
  output logic                dm_req,
  output logic                dm_we,
  output logic                illegal,
  output logic                retire,
  output logic [CNT_W-1:0]    inst_cnt
);

  cu_state_t   state;
  inst_class_t cls;

  // The shift amount is consumed by the datapath, not by control
  logic unused_sa;
  assign unused_sa = ^sa;

  cu_decoder #(.ALU_OP_W(ALU_OP_W)) u_decoder (
    .op          (op),
    .func        (func),
    .cls         (cls),
    .alu_op      (alu_op),
    .src1_is_sa  (src1_is_sa),
    .src2_is_imm (src2_is_imm),
    .imm_zext    (imm_zext),
    .dst_is_rt   (dst_is_rt),
    .reg_from_dm (reg_from_dm)
  );

  // State sequencing and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IF;
      inst_cnt <= '0;
    end else begin
      if (retire) inst_cnt <= inst_cnt + CNT_W'(1);
      case (state)
        S_IF:  if (inst_ready) state <= S_ID;
        S_ID:  state <= (cls.jump || cls.illegal) ? S_IF : S_EX;
        S_EX: begin
          if (cls.branch)                 state <= S_IF;
          else if (cls.load || cls.store) state <= S_MEM;
          else                            state <= S_WB;
        end
        S_MEM: if (dm_ready) state <= cls.store ? S_IF : S_WB;
        S_WB:  state <= S_IF;
        default: state <= S_IF;
      endcase
    end
  end

  // Strobes from the registered state plus the ready/zero inputs of that state
  always_comb begin
    inst_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = NPC_SEQ;
    reg_we   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    if (resetn) begin
      case (state)
        S_IF: begin
          inst_req = 1'b1;
          ir_we    = inst_ready;
          pc_we    = inst_ready;
        end
        S_ID: begin
          if (cls.jump) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JUMP;
            retire  = 1'b1;
          end else if (cls.illegal) begin
            illegal = 1'b1;
          end
        end
        S_EX: begin
          if (cls.branch) begin
            pc_we   = cls.br_ne ? ~alu_zero : alu_zero;
            npc_sel = NPC_BRANCH;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = cls.store;
          retire = dm_ready && cls.store;
        end
        S_WB: begin
          reg_we = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
